// File: rtl/knn_topk.sv
// knn_topk: keeps the K nearest (distance, label) samples of one query stream in
// ascending order, then returns a majority vote over the kept labels.
module knn_topk #(
    parameter int K       = 4,
    parameter int DIST_W  = 64,
    parameter int LABEL_W = 8,
    localparam int CNT_W  = $clog2(K + 1),
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [CNT_W-1:0]   out_count,
    output logic [DIST_W-1:0]  out_dist
);
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_VOTE = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_r;
    logic [K-1:0]       valid_r;
    logic [DIST_W-1:0]  dist_r [K];
    logic [LABEL_W-1:0] label_r [K];
    logic [IDX_W-1:0]   vote_idx_r;
    logic [CNT_W-1:0]   best_cnt_r;
    logic [LABEL_W-1:0] best_label_r;

    logic [CNT_W-1:0]   pos_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [K-1:0]       ins_valid_s;
    logic [DIST_W-1:0]  ins_dist_s [K];
    logic [LABEL_W-1:0] ins_label_s [K];
    logic               win_s;
    logic [CNT_W-1:0]   best_cnt_nx_s;
    logic [LABEL_W-1:0] best_label_nx_s;

    // Insert position: valid entries with dist <= new dist, so equal distances keep arrival order
    always_comb begin
        pos_s = {CNT_W{1'b0}};
        for (int j = 0; j < K; j++) begin
            pos_s = pos_s + ((valid_r[j] && (dist_r[j] <= in_dist)) ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Candidate list with the new sample placed at pos_s and the tail shifted up
    always_comb begin
        ins_valid_s[0] = (pos_s == {CNT_W{1'b0}}) ? 1'b1     : valid_r[0];
        ins_dist_s[0]  = (pos_s == {CNT_W{1'b0}}) ? in_dist  : dist_r[0];
        ins_label_s[0] = (pos_s == {CNT_W{1'b0}}) ? in_label : label_r[0];
        for (int j = 1; j < K; j++) begin
            if (CNT_W'(j) < pos_s) begin
                ins_valid_s[j] = valid_r[j];
                ins_dist_s[j]  = dist_r[j];
                ins_label_s[j] = label_r[j];
            end else if (CNT_W'(j) == pos_s) begin
                ins_valid_s[j] = 1'b1;
                ins_dist_s[j]  = in_dist;
                ins_label_s[j] = in_label;
            end else begin
                ins_valid_s[j] = valid_r[j-1];
                ins_dist_s[j]  = dist_r[j-1];
                ins_label_s[j] = label_r[j-1];
            end
        end
    end

    // Vote step: occurrences of the current entry's label; strict > keeps the nearer label on ties
    always_comb begin
        cnt_s = {CNT_W{1'b0}};
        for (int j = 0; j < K; j++) begin
            cnt_s = cnt_s + ((valid_r[j] && (label_r[j] == label_r[vote_idx_r])) ? CNT_W'(1) : CNT_W'(0));
        end
        win_s = valid_r[vote_idx_r] && (cnt_s > best_cnt_r);
        if (win_s) begin
            best_cnt_nx_s   = cnt_s;
            best_label_nx_s = label_r[vote_idx_r];
        end else begin
            best_cnt_nx_s   = best_cnt_r;
            best_label_nx_s = best_label_r;
        end
    end

    // Control FSM, sorted list storage and registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_FILL;
            in_ready     <= 1'b1;
            valid_r      <= {K{1'b0}};
            for (int j = 0; j < K; j++) begin
                dist_r[j]  <= {DIST_W{1'b1}};
                label_r[j] <= {LABEL_W{1'b0}};
            end
            vote_idx_r   <= {IDX_W{1'b0}};
            best_cnt_r   <= {CNT_W{1'b0}};
            best_label_r <= {LABEL_W{1'b0}};
            out_valid    <= 1'b0;
            out_label    <= {LABEL_W{1'b0}};
            out_count    <= {CNT_W{1'b0}};
            out_dist     <= {DIST_W{1'b1}};
        end else if (clr) begin
            state_r   <= ST_FILL;
            in_ready  <= 1'b1;
            valid_r   <= {K{1'b0}};
            for (int j = 0; j < K; j++) begin
                dist_r[j]  <= {DIST_W{1'b1}};
                label_r[j] <= {LABEL_W{1'b0}};
            end
            out_valid <= 1'b0;
            out_label <= {LABEL_W{1'b0}};
            out_count <= {CNT_W{1'b0}};
            out_dist  <= {DIST_W{1'b1}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_valid && in_ready) begin
                        if (pos_s != CNT_W'(K)) begin
                            valid_r <= ins_valid_s;
                            for (int j = 0; j < K; j++) begin
                                dist_r[j]  <= ins_dist_s[j];
                                label_r[j] <= ins_label_s[j];
                            end
                        end
                        if (in_last) begin
                            state_r      <= ST_VOTE;
                            in_ready     <= 1'b0;
                            vote_idx_r   <= {IDX_W{1'b0}};
                            best_cnt_r   <= {CNT_W{1'b0}};
                            best_label_r <= {LABEL_W{1'b0}};
                        end
                    end
                end
                ST_VOTE: begin
                    best_cnt_r   <= best_cnt_nx_s;
                    best_label_r <= best_label_nx_s;
                    if (vote_idx_r == IDX_W'(K - 1)) begin
                        state_r   <= ST_OUT;
                        out_valid <= 1'b1;
                        out_label <= best_label_nx_s;
                        out_count <= best_cnt_nx_s;
                        out_dist  <= dist_r[0];
                    end else begin
                        vote_idx_r <= vote_idx_r + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r   <= ST_FILL;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        valid_r   <= {K{1'b0}};
                        for (int j = 0; j < K; j++) begin
                            dist_r[j]  <= {DIST_W{1'b1}};
                            label_r[j] <= {LABEL_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r   <= ST_FILL;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
